// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Brief    : Opcodes, FSM states, flag indices and decode helper for wb_pipe.
// Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam logic [4:0] OP_ST   = 5'b10000,
                           OP_LD   = 5'b10001,
                           OP_SLBI = 5'b10010,
                           OP_LBI  = 5'b11000,
                           OP_BTR  = 5'b11001,
                           OP_SEQ  = 5'b11100,
                           OP_SLT  = 5'b11101,
                           OP_SLE  = 5'b11110,
                           OP_SCO  = 5'b11111;

    // Bit positions inside the {ovf,lte,lt,zero} flag bundle
    localparam int FLG_ZERO = 0,
                   FLG_LT   = 1,
                   FLG_LTE  = 2,
                   FLG_OVF  = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        LWAIT = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_ALU  = 3'd1,
        SRC_IMM  = 3'd2,
        SRC_BTR  = 3'd3,
        SRC_SLBI = 3'd4,
        SRC_FLG  = 3'd5,
        SRC_PC2  = 3'd6,
        SRC_LD   = 3'd7
    } src_e;

    function automatic src_e decode_src(input logic [4:0] op);
        casez (op)
            5'b010??, 5'b101??, 5'b10011, 5'b1101?: decode_src = SRC_ALU;
            OP_LBI:                                 decode_src = SRC_IMM;
            OP_BTR:                                 decode_src = SRC_BTR;
            OP_SLBI:                                decode_src = SRC_SLBI;
            5'b111??:                               decode_src = SRC_FLG;
            5'b0011?:                               decode_src = SRC_PC2;
            OP_LD:                                  decode_src = SRC_LD;
            default:                                decode_src = SRC_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_rev.sv
`default_nettype none
// ============================================================================
// Module   : bit_rev
// Brief    : Combinational bit reversal over WIDTH bits.
// Revision : 1.0 - initial release
// ============================================================================
module bit_rev #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign dout[i] = din[WIDTH-1-i];
    end

endmodule
`default_nettype wire

// File: rtl/wb_pipe.sv
`default_nettype none
// ============================================================================
// Module   : wb_pipe
// Brief    : Write-back stage with load wait/timeout; WB_PIPE_FWD_EN adds a
//            one-cycle-early forward port.
// Revision : 1.0 - initial release
// ============================================================================
module wb_pipe
    import wb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int TMO    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [15:0]       ex_instr,
    input  logic [DATA_W-1:0] ex_alu,
    input  logic [DATA_W-1:0] ex_rs,
    input  logic [DATA_W-1:0] ex_pc2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [3:0]        ex_flg,
    input  logic              flush,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              err
`ifdef WB_PIPE_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    state_e              state, state_nxt;
    logic [7:0]          cnt, cnt_nxt;
    logic                err_nxt, discard, discard_nxt;
    logic [REG_AW-1:0]   ld_rd, ld_rd_nxt, addr_nxt;
    logic [DATA_W-1:0]   data_nxt, sel_data, rev_rs;
    logic                we_nxt, flg_bit, rv_live;
    logic [4:0]          op;
    src_e                src;
    logic                unused_instr;

    assign op           = ex_instr[15:11];
    assign src          = decode_src(op);
    assign rv_live      = mem_rvalid && !discard;
    assign unused_instr = ^ex_instr[10:8];

    bit_rev #(.WIDTH(DATA_W)) u_bit_rev (
        .din  (ex_rs),
        .dout (rev_rs)
    );

    always_comb begin
        case (op)
            OP_SEQ:  flg_bit = ex_flg[FLG_ZERO];
            OP_SLT:  flg_bit = ex_flg[FLG_LT];
            OP_SLE:  flg_bit = ex_flg[FLG_LTE];
            default: flg_bit = ex_flg[FLG_OVF];
        endcase
    end

    always_comb begin
        case (src)
            SRC_IMM:  sel_data = {{(DATA_W-8){ex_instr[7]}}, ex_instr[7:0]};
            SRC_BTR:  sel_data = rev_rs;
            SRC_SLBI: sel_data = {ex_rs[DATA_W-9:0], ex_instr[7:0]};
            SRC_FLG:  sel_data = {{(DATA_W-1){1'b0}}, flg_bit};
            SRC_PC2:  sel_data = ex_pc2;
            default:  sel_data = ex_alu;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        err_nxt     = err;
        discard_nxt = discard;
        ld_rd_nxt   = ld_rd;
        we_nxt      = 1'b0;
        addr_nxt    = wb_addr;
        data_nxt    = wb_data;
        ex_ready    = (state == IDLE) || rst;

        // A return that arrives while discarding is the stale one
        if (discard && mem_rvalid) begin
            discard_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                if (ex_valid && ex_ready && !flush) begin
                    if (src == SRC_LD) begin
                        ld_rd_nxt = ex_rd;
                        cnt_nxt   = 8'd0;
                        state_nxt = LWAIT;
                    end else if (src != SRC_NONE) begin
                        we_nxt   = 1'b1;
                        addr_nxt = ex_rd;
                        data_nxt = sel_data;
                    end
                end
            end
            LWAIT: begin
                if (rv_live) begin
                    we_nxt    = 1'b1;
                    addr_nxt  = ld_rd;
                    data_nxt  = mem_rdata;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                    if (cnt == 8'(TMO - 1)) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (flush) begin
            we_nxt    = 1'b0;
            addr_nxt  = wb_addr;
            data_nxt  = wb_data;
            err_nxt   = err;
            state_nxt = IDLE;
            // An outstanding load whose return did not coincide must be dropped later
            if (state == LWAIT) begin
                discard_nxt = !rv_live;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            err     <= 1'b0;
            discard <= 1'b0;
            ld_rd   <= '0;
            wb_we   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            err     <= err_nxt;
            discard <= discard_nxt;
            ld_rd   <= ld_rd_nxt;
            wb_we   <= we_nxt;
            wb_addr <= addr_nxt;
            wb_data <= data_nxt;
        end
    end

`ifdef WB_PIPE_FWD_EN
    assign fwd_valid = we_nxt && !rst;
    assign fwd_addr  = addr_nxt;
    assign fwd_data  = data_nxt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_pipe
// Brief    : Scoreboard bench for wb_pipe at DATA_W=16 and DATA_W=32.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_pipe;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, valid16, valid32, mem_rvalid;
    logic [15:0] ex_instr;
    logic [31:0] ex_alu, ex_rs, ex_pc2, mem_rdata;
    logic [2:0]  ex_rd;
    logic [3:0]  ex_flg;

    logic        ready16, we16, err16, ready32, we32, err32;
    logic [2:0]  addr16, addr32;
    logic [15:0] data16;
    logic [31:0] data32;
`ifdef WB_PIPE_FWD_EN
    logic        fv16, fv32;
    logic [2:0]  fa16, fa32;
    logic [15:0] fd16;
    logic [31:0] fd32;
`endif

    exp_t q16[$];
    exp_t q32[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    wb_pipe #(.DATA_W(16), .REG_AW(3), .TMO(15)) dut16 (
        .clk(clk), .rst(rst), .ex_valid(valid16), .ex_ready(ready16),
        .ex_instr(ex_instr), .ex_alu(ex_alu[15:0]), .ex_rs(ex_rs[15:0]),
        .ex_pc2(ex_pc2[15:0]), .ex_rd(ex_rd), .ex_flg(ex_flg), .flush(flush),
        .mem_rdata(mem_rdata[15:0]), .mem_rvalid(mem_rvalid),
        .wb_we(we16), .wb_addr(addr16), .wb_data(data16), .err(err16)
`ifdef WB_PIPE_FWD_EN
        , .fwd_valid(fv16), .fwd_addr(fa16), .fwd_data(fd16)
`endif
    );

    wb_pipe #(.DATA_W(32), .REG_AW(3), .TMO(15)) dut32 (
        .clk(clk), .rst(rst), .ex_valid(valid32), .ex_ready(ready32),
        .ex_instr(ex_instr), .ex_alu(ex_alu), .ex_rs(ex_rs),
        .ex_pc2(ex_pc2), .ex_rd(ex_rd), .ex_flg(ex_flg), .flush(flush),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .wb_we(we32), .wb_addr(addr32), .wb_data(data32), .err(err32)
`ifdef WB_PIPE_FWD_EN
        , .fwd_valid(fv32), .fwd_addr(fa32), .fwd_data(fd32)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single cycle; a writing op queues its expected write
    task automatic issue(input bit w32, input logic [15:0] instr,
                         input logic [31:0] alu, input logic [31:0] rs,
                         input logic [31:0] pc2, input logic [2:0] rd,
                         input logic [3:0] flg, input bit wr, input logic [31:0] exp);
        exp_t e;
        ex_instr = instr; ex_alu = alu; ex_rs = rs; ex_pc2 = pc2;
        ex_rd = rd; ex_flg = flg;
        e.addr = rd; e.data = exp;
        if (w32) begin
            valid32 = 1'b1;
            if (wr) q32.push_back(e);
        end else begin
            valid16 = 1'b1;
            if (wr) q16.push_back(e);
        end
        step();
        valid16 = 1'b0;
        valid32 = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && we16) begin
            if (q16.size() == 0) check("wr16_unexpected", 1, 0);
            else begin
                exp_t e;
                e = q16.pop_front();
                check("wr16_addr", 64'(addr16), 64'(e.addr));
                check("wr16_data", 64'(data16), 64'(e.data[15:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && we32) begin
            if (q32.size() == 0) check("wr32_unexpected", 1, 0);
            else begin
                exp_t e;
                e = q32.pop_front();
                check("wr32_addr", 64'(addr32), 64'(e.addr));
                check("wr32_data", 64'(data32), 64'(e.data));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; valid16 = 1'b0; valid32 = 1'b0;
        mem_rvalid = 1'b0; mem_rdata = '0; ex_instr = '0; ex_alu = '0;
        ex_rs = '0; ex_pc2 = '0; ex_rd = '0; ex_flg = '0;
        repeat (2) step();
        check("rst_ready", ready16, 1);
        check("rst_we", we16, 0);
        check("rst_addr", addr16, 0);
        check("rst_data", data16, 0);
        check("rst_err", err16, 0);
        check("rst_ready32", ready32, 1);
        rst = 1'b0;
        step();

        // LBI: sign-extended immediate, one-cycle write pulse
        issue(0, 16'hC0F3, 32'h1111, 32'h2222, 32'h3333, 3'd2, 4'h0, 1, 32'hFFF3);
        check("lbi_lat_we", we16, 1);
        check("lbi_addr", addr16, 2);
        check("lbi_data", data16, 16'hFFF3);
        step();
        check("lbi_pulse", we16, 0);
        check("lbi_hold", data16, 16'hFFF3);

        // Back-to-back data-source variety
        issue(0, 16'h4000, 32'hBEEF, 32'h1234, 32'h7777, 3'd3, 4'h0, 1, 32'hBEEF);
        issue(0, 16'hA000, 32'h0A0A, 32'h1234, 32'h7777, 3'd0, 4'h0, 1, 32'h0A0A);
        issue(0, 16'h90A5, 32'h0A0A, 32'h1234, 32'h7777, 3'd4, 4'h0, 1, 32'h34A5);
        issue(0, 16'hC800, 32'h0A0A, 32'h1234, 32'h7777, 3'd1, 4'h0, 1, 32'h2C48);
        issue(0, 16'hE800, 32'h0A0A, 32'h1234, 32'h7777, 3'd6, 4'b0010, 1, 32'h0001);
        issue(0, 16'hF000, 32'h0A0A, 32'h1234, 32'h7777, 3'd6, 4'b0010, 1, 32'h0000);
        issue(0, 16'hF800, 32'h0A0A, 32'h1234, 32'h7777, 3'd5, 4'b1000, 1, 32'h0001);
        issue(0, 16'h3800, 32'h0A0A, 32'h1234, 32'h0102, 3'd7, 4'h0, 1, 32'h0102);
        issue(0, 16'h8000, 32'h0A0A, 32'h1234, 32'h7777, 3'd2, 4'h0, 0, 32'h0);
        check("st_nowr", we16, 0);
        check("st_hold_data", data16, 16'h0102);
        check("st_hold_addr", addr16, 7);
        issue(0, 16'h0000, 32'h0A0A, 32'h1234, 32'h7777, 3'd2, 4'h0, 0, 32'h0);
        issue(0, 16'hD000, 32'h00C3, 32'h1234, 32'h7777, 3'd3, 4'h0, 1, 32'h00C3);

        // Load with return after three wait cycles
        q16.push_back('{addr: 3'd5, data: 32'h1234});
        issue(0, 16'h8800, 32'h0, 32'h0, 32'h0, 3'd5, 4'h0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("ld_busy", ready16, 0);
            step();
        end
        check("ld_busy4", ready16, 0);
        mem_rvalid = 1'b1; mem_rdata = 32'h1234;
        step();
        mem_rvalid = 1'b0;
        check("ld_wr", we16, 1);
        check("ld_ready", ready16, 1);
        step();

        // Load that times out
        issue(0, 16'h8800, 32'h0, 32'h0, 32'h0, 3'd6, 4'h0, 0, 32'h0);
        for (int i = 0; i < 15; i++) begin
            if (i == 0 || i == 14) begin
                check("tmo_busy", ready16, 0);
                check("tmo_noerr", err16, 0);
            end
            step();
        end
        check("tmo_err", err16, 1);
        check("tmo_idle", ready16, 1);
        step();
        check("tmo_sticky", err16, 1);

        // Flush during load wait; stale return dropped, then SEQ
        issue(0, 16'h8800, 32'h0, 32'h0, 32'h0, 3'd1, 4'h0, 0, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_idle", ready16, 1);
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD;
        step();
        mem_rvalid = 1'b0;
        check("stale_drop", we16, 0);
        issue(0, 16'hE000, 32'h0, 32'h0, 32'h0, 3'd2, 4'b0001, 1, 32'h0001);
        check("seq_wr", we16, 1);

        // Op presented together with flush is not accepted
        ex_instr = 16'hC011; ex_rd = 3'd4; valid16 = 1'b1; flush = 1'b1;
        step();
        valid16 = 1'b0; flush = 1'b0;
        check("flush_op_drop", we16, 0);
        step();
        check("flush_op_drop2", we16, 0);

        // Flush coinciding with return: consumed, next load's return is live
        issue(0, 16'h8800, 32'h0, 32'h0, 32'h0, 3'd2, 4'h0, 0, 32'h0);
        flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h9999;
        step();
        flush = 1'b0; mem_rvalid = 1'b0;
        check("flush_rv_nowr", we16, 0);
        q16.push_back('{addr: 3'd3, data: 32'h5555});
        issue(0, 16'h8800, 32'h0, 32'h0, 32'h0, 3'd3, 4'h0, 0, 32'h0);
        mem_rvalid = 1'b1; mem_rdata = 32'h5555;
        step();
        mem_rvalid = 1'b0;
        check("ld_after_consume", we16, 1);
        step();

        // Reset abandons a pending load
        issue(0, 16'h8800, 32'h0, 32'h0, 32'h0, 3'd4, 4'h0, 0, 32'h0);
        rst = 1'b1;
        step();
        check("rst_ld_ready", ready16, 1);
        check("rst_ld_err", err16, 0);
        check("rst_ld_we", we16, 0);
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h4444;
        step();
        mem_rvalid = 1'b0;
        check("idle_rv_ignored", we16, 0);
        step();

        // Wide datapath
        issue(1, 16'hC800, 32'h0, 32'h0000_0001, 32'h0, 3'd1, 4'h0, 1, 32'h8000_0000);
        check("btr32_we", we32, 1);
        issue(1, 16'hC080, 32'h0, 32'h0, 32'h0, 3'd2, 4'h0, 1, 32'hFFFF_FF80);
        issue(1, 16'h8000, 32'h0, 32'h0, 32'h0, 3'd6, 4'h0, 0, 32'h0);
        check("st32_nowr", we32, 0);
        check("st32_hold", data32, 32'hFFFF_FF80);

        repeat (3) step();
        check("q16_drained", 64'(q16.size()), 0);
        check("q32_drained", 64'(q32.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
